// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StFix  = 2'd2;

    // Bit counter must hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [63:0] dbz_quotient(input int unsigned width);
        return (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/div_mag.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_mag #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? ((~in_val) + WIDTH'(1)) : in_val;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Optional divide-by-zero fast path and flag when SEQ_DIVIDER_DBZ_EN is defined.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;

    logic [WIDTH-1:0]  dvd_mag, dvs_mag, q_fix, r_fix;
    logic [WIDTH+1:0]  shifted;
    logic [WIDTH:0]    diff;
    logic              fits;

    div_mag #(.WIDTH(WIDTH)) u_mag_dvd (
        .in_val (dividend),
        .neg    (sign & dividend[WIDTH-1]),
        .out_val(dvd_mag)
    );

    div_mag #(.WIDTH(WIDTH)) u_mag_dvs (
        .in_val (divisor),
        .neg    (sign & divisor[WIDTH-1]),
        .out_val(dvs_mag)
    );

    div_mag #(.WIDTH(WIDTH)) u_fix_q (
        .in_val (acc_q),
        .neg    (qneg_q),
        .out_val(q_fix)
    );

    div_mag #(.WIDTH(WIDTH)) u_fix_r (
        .in_val (rem_q[WIDTH-1:0]),
        .neg    (rneg_q),
        .out_val(r_fix)
    );

    // Restoring step: partial remainder shifted with the next dividend bit, then trial subtract.
    assign shifted = {rem_q, acc_q[WIDTH-1]};
    assign fits    = (shifted >= {2'b00, dvs_q});
    assign diff    = shifted[WIDTH:0] - {1'b0, dvs_q};

`ifdef SEQ_DIVIDER_DBZ_EN
    localparam logic [WIDTH-1:0] DbzQuot = WIDTH'(dbz_quotient(WIDTH));
    logic dbz_pend_q, dbz_pend_d;
    logic dbz_q, dbz_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_DBZ_EN
        dbz_pend_d  = dbz_pend_q;
        dbz_d       = dbz_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = '0;
                    acc_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    qneg_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = sign & dividend[WIDTH-1];
                    cnt_d   = CntW'(WIDTH);
                    state_d = StCalc;
`ifdef SEQ_DIVIDER_DBZ_EN
                    dbz_pend_d = (divisor == '0);
                    if (divisor == '0) begin
                        // Preload the final result so FIX passes it through unchanged.
                        acc_d   = DbzQuot;
                        rem_d   = {1'b0, dividend};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = StFix;
                    end
`endif
                end
            end
            StCalc: begin
                rem_d = fits ? diff : shifted[WIDTH:0];
                acc_d = {acc_q[WIDTH-2:0], fits};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                done_d      = 1'b1;
                state_d     = StIdle;
`ifdef SEQ_DIVIDER_DBZ_EN
                dbz_d       = dbz_pend_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

`ifdef SEQ_DIVIDER_DBZ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
        end
    end
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=8 (directed) and WIDTH=32 (random).
module tb_seq_divider;

`ifdef SEQ_DIVIDER_DBZ_EN
    localparam bit DbzEn = 1'b1;
`else
    localparam bit DbzEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, sign8 = 1'b0;
    logic [7:0]  dvd8 = '0, dvs8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;
    logic        start32 = 1'b0, sign32 = 1'b0;
    logic [31:0] dvd32 = '0, dvs32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sign(sign8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .dbz(dbz8)
    );

    seq_divider #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sign(sign32),
        .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .dbz(dbz32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation for signed operands.
    function automatic void ref_div(input int w, input logic s, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] q,
                                    output logic [63:0] r);
        longint sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (b == 64'd0) begin
            q = mask;
            r = a;
        end else if (s) begin
            sa = longint'(a << (64 - w)) >>> (64 - w);
            sb = longint'(b << (64 - w)) >>> (64 - w);
            q  = 64'(sa / sb) & mask;
            r  = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done32;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction

    function automatic logic [63:0] get_q(input int w);
        return (w == 8) ? {56'd0, q8} : {32'd0, q32};
    endfunction

    function automatic logic [63:0] get_r(input int w);
        return (w == 8) ? {56'd0, r8} : {32'd0, r32};
    endfunction

    function automatic logic get_dbz(input int w);
        return (w == 8) ? dbz8 : dbz32;
    endfunction

    task automatic run_op(input int w, input logic s, input logic [63:0] a, input logic [63:0] b,
                          input string tag);
        logic [63:0] eq, er;
        int lat;
        bit busy_ok, zero_div;
        zero_div = (b == 64'd0);
        @(negedge clk);
        if (w == 8) begin
            sign8 = s; dvd8 = a[7:0]; dvs8 = b[7:0]; start8 = 1'b1;
        end else begin
            sign32 = s; dvd32 = a[31:0]; dvs32 = b[31:0]; start32 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start32 = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!get_done(w) && lat < 200) begin
            if (!get_busy(w)) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), (DbzEn && zero_div) ? 64'd1 : 64'(w + 1));
        check({tag, " busy while running"}, {63'd0, busy_ok}, 64'd1);
        check({tag, " busy at done"}, {63'd0, get_busy(w)}, 64'd0);
        ref_div(w, s, a, b, eq, er);
        if (!(s && zero_div && !DbzEn)) begin
            check({tag, " quotient"}, get_q(w), eq);
            check({tag, " remainder"}, get_r(w), er);
        end
        check({tag, " dbz"}, {63'd0, get_dbz(w)}, {63'd0, DbzEn && zero_div});
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, {63'd0, get_done(w)}, 64'd0);
        if (!(s && zero_div && !DbzEn)) check({tag, " quotient held"}, get_q(w), eq);
    endtask

    initial begin
        logic [7:0]  bb_a [3];
        logic [7:0]  bb_b [3];
        logic        bb_s [3];
        logic [63:0] eq, er;
        logic [63:0] ra, rb;
        logic        rs;
        int          cyc;
        bit          seen;

        #3;
        check("reset busy", {63'd0, busy8}, 64'd0);
        check("reset done", {63'd0, done8}, 64'd0);
        check("reset quotient", {56'd0, q8}, 64'd0);
        check("reset remainder", {56'd0, r8}, 64'd0);
        check("reset dbz", {63'd0, dbz8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8, 1'b0, 64'd200, 64'd7, "u 200/7");
        run_op(8, 1'b1, 64'hF9, 64'h02, "s -7/2");
        run_op(8, 1'b1, 64'h07, 64'hFE, "s 7/-2");
        run_op(8, 1'b1, 64'h80, 64'hFF, "s overflow");
        run_op(8, 1'b0, 64'h80, 64'hFF, "u 128/255");
        run_op(8, 1'b1, 64'h80, 64'h01, "s minneg/1");
        run_op(8, 1'b0, 64'h55, 64'h00, "u div zero");
        run_op(8, 1'b0, 64'd9, 64'd4, "after zero");

        // Start held high: ignored while busy, operands scrambled meanwhile.
        bb_a = '{8'd250, 8'hF9, 8'd77};
        bb_b = '{8'd13, 8'h03, 8'd77};
        bb_s = '{1'b0, 1'b1, 1'b0};
        @(negedge clk);
        sign8 = bb_s[0]; dvd8 = bb_a[0]; dvs8 = bb_b[0]; start8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
                if (!done8 && busy8) begin
                    dvd8 = 8'($urandom); dvs8 = 8'($urandom); sign8 = 1'($urandom);
                end
            end while (!done8 && cyc < 100);
            check($sformatf("b2b %0d spacing", k), 64'(cyc), 64'd10);
            ref_div(8, bb_s[k], {56'd0, bb_a[k]}, {56'd0, bb_b[k]}, eq, er);
            check($sformatf("b2b %0d quotient", k), {56'd0, q8}, eq);
            check($sformatf("b2b %0d remainder", k), {56'd0, r8}, er);
            if (k < 2) begin
                sign8 = bb_s[k+1]; dvd8 = bb_a[k+1]; dvs8 = bb_b[k+1];
            end else begin
                start8 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b no extra done", {63'd0, done8}, 64'd0);

        // Reset in the middle of a calculation.
        run_op(8, 1'b0, 64'd200, 64'd7, "pre reset");
        @(negedge clk);
        sign8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd3; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", {63'd0, busy8}, 64'd0);
        check("midrst done", {63'd0, done8}, 64'd0);
        check("midrst quotient", {56'd0, q8}, 64'd0);
        check("midrst remainder", {56'd0, r8}, 64'd0);
        check("midrst dbz", {63'd0, dbz8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) seen = 1'b1;
        end
        check("midrst no done", {63'd0, seen}, 64'd0);
        run_op(8, 1'b0, 64'd100, 64'd3, "after reset 100/3");

        // Random operands at WIDTH=32, biased toward corner values.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = {32'd0, $urandom};
            case ($urandom_range(0, 3))
                0: rb = {32'd0, $urandom};
                1: rb = 64'($urandom_range(1, 15));
                2: begin
                    rb = 64'hFFFF_FFFF;
                    ra = 64'h8000_0000;
                end
                default: rb = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'h8000_0000;
            endcase
            run_op(32, rs, ra, rb, $sformatf("rnd%0d %s", i, rs ? "s" : "u"));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
